// File: rtl/anim_box_pkg.sv
// Shared types and constants for the bouncing-box overlay generator.
package anim_box_pkg;

  localparam int C_COORD_W = 12;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

  // A divider of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int tickCntWidth(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/anim_box_axis.sv
// One motion axis: a position that sweeps 0..LIM and back, plus a range test
// of the scan coordinate against [pos, pos+SIZE).
module anim_box_axis
  import anim_box_pkg::*;
#(
  parameter int LIM  = 8,
  parameter int SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [C_COORD_W-1:0] coord,
  output logic [C_COORD_W-1:0] pos,
  output logic                 in_range
);

  localparam logic [C_COORD_W-1:0] C_LIM  = C_COORD_W'(LIM);
  localparam logic [C_COORD_W:0]   C_SIZE = (C_COORD_W + 1)'(SIZE);

  logic [C_COORD_W-1:0] r_pos;
  dir_e                 r_dir;
  logic [C_COORD_W:0]   w_coord;
  logic [C_COORD_W:0]   w_lo;
  logic [C_COORD_W:0]   w_hi;

  // At each end the direction flips and the step is taken in the new
  // direction on the same tick, so the endpoint is held for one step only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= DIR_INC;
    end else if (tick) begin
      unique case (r_dir)
        DIR_INC: begin
          if (r_pos < C_LIM) begin
            r_pos <= r_pos + 1'b1;
          end else begin
            r_dir <= DIR_DEC;
            r_pos <= r_pos - 1'b1;
          end
        end
        DIR_DEC: begin
          if (r_pos != '0) begin
            r_pos <= r_pos - 1'b1;
          end else begin
            r_dir <= DIR_INC;
            r_pos <= r_pos + 1'b1;
          end
        end
        default: begin
          r_pos <= '0;
          r_dir <= DIR_INC;
        end
      endcase
    end
  end

  // One extra bit keeps pos+SIZE from wrapping onto low coordinates.
  assign w_coord  = {1'b0, coord};
  assign w_lo     = {1'b0, r_pos};
  assign w_hi     = w_lo + C_SIZE;
  assign in_range = (w_coord >= w_lo) && (w_coord < w_hi);
  assign pos      = r_pos;

endmodule

// File: rtl/anim_box.sv
// Bouncing-square overlay: flags scan pixels that fall inside a box moving
// diagonally and reflecting off the edges of the motion area.
module anim_box
  import anim_box_pkg::*;
#(
  parameter int P_MAX_X    = 959,
  parameter int P_MAX_Y    = 1199,
  parameter int P_SIZE     = 32,
  parameter int P_TICK_DIV = 200000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [C_COORD_W-1:0] x,
  input  logic [C_COORD_W-1:0] y,
  output logic                 out
);

  localparam int                 C_CNT_W    = tickCntWidth(P_TICK_DIV);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(P_TICK_DIV - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_out;
  logic               w_tick;
  logic               w_inX;
  logic               w_inY;

  assign w_tick = (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  anim_box_axis #(
    .LIM  (P_MAX_X - P_SIZE),
    .SIZE (P_SIZE)
  ) u_axisX (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (w_tick),
    .coord    (x),
    .pos      (),
    .in_range (w_inX)
  );

  anim_box_axis #(
    .LIM  (P_MAX_Y - P_SIZE),
    .SIZE (P_SIZE)
  ) u_axisY (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (w_tick),
    .coord    (y),
    .pos      (),
    .in_range (w_inY)
  );

  // The hit uses the position held before this edge's motion update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= 1'b0;
    end else begin
      r_out <= w_inX & w_inY;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_anim_box.sv
// Randomized self-checking bench: two anim_box instances (divider 4 and 1)
// compared against a triangle-wave model of the box position.
module tb_anim_box;

  localparam int SIZE = 32;
  localparam int DIV  = 4;
  localparam int MAXX = 40;
  localparam int MAXY = 1199;
  localparam int LIMX = MAXX - SIZE;
  localparam int LIMY = MAXY - SIZE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic        outDiv;
  logic        outFast;

  int checks = 0;
  int passes = 0;
  int k = 0;
  logic expDiv = 1'b0;
  logic expFast = 1'b0;
  bit pending = 1'b0;

  always #5 clk = ~clk;

  anim_box #(
    .P_MAX_X(MAXX), .P_MAX_Y(MAXY), .P_SIZE(SIZE), .P_TICK_DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .out(outDiv)
  );

  anim_box #(
    .P_MAX_X(MAXX), .P_MAX_Y(MAXY), .P_SIZE(SIZE), .P_TICK_DIV(1)
  ) dutFast (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .out(outFast)
  );

  // Position after n motion steps: a triangle wave bouncing between 0 and lim.
  function automatic int triPos(input int n, input int lim);
    int m;
    m = n % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic logic hit(input int xv, input int yv, input int px, input int py);
    return (xv >= px) && (xv < px + SIZE) && (yv >= py) && (yv < py + SIZE);
  endfunction

  function automatic int wrap12(input int v);
    return ((v % 4096) + 4096) % 4096;
  endfunction

  function automatic int nearCoord(input int p);
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return $urandom_range(0, 4095);
      1:       return wrap12(p - 1);
      2:       return p;
      3:       return p + SIZE - 1;
      4:       return p + SIZE;
      default: return wrap12(p + $urandom_range(0, 40) - 4);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %b expected %b (t=%0t, k=%0d)", tag, observed, expected, $time, k);
  endtask

  // One clock: check the previous cycle's prediction, drive new inputs, and
  // predict what out must show after the coming edge.
  task automatic applyStimulus(input logic rstv, input int xv, input int yv);
    @(negedge clk);
    if (pending) begin
      checkOutput("out_div4", outDiv, expDiv);
      checkOutput("out_div1", outFast, expFast);
    end
    rst_n = rstv;
    x = 12'(xv);
    y = 12'(yv);
    if (rstv) begin
      expDiv  = hit(xv, yv, triPos(k / DIV, LIMX), triPos(k / DIV, LIMY));
      expFast = hit(xv, yv, triPos(k, LIMX), triPos(k, LIMY));
      k++;
    end else begin
      expDiv  = 1'b0;
      expFast = 1'b0;
      k = 0;
    end
    pending = 1'b1;
  endtask

  initial begin
    int px;
    int py;
    repeat (3) applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 31, 31);
    applyStimulus(1'b1, 32, 0);
    applyStimulus(1'b1, 0, 32);
    applyStimulus(1'b1, 4095, 0);
    applyStimulus(1'b1, 0, 1);
    applyStimulus(1'b1, 1, 1);
    applyStimulus(1'b1, 32, 32);
    applyStimulus(1'b1, 33, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b0, $urandom_range(0, 4095), $urandom_range(0, 4095));
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          px = triPos(k / DIV, LIMX);
          py = triPos(k / DIV, LIMY);
        end else begin
          px = triPos(k, LIMX);
          py = triPos(k, LIMY);
        end
        applyStimulus(1'b1, nearCoord(px), nearCoord(py));
      end
    end

    applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 0, 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
